rock_strategy: RTL and testbench
================================

ROCK_STRATEGY -- requirements
Module: rock_strategy

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning cycles waited after start or after each issued command before cry is sampled (legal range 1..255).
REQ-002 SHALL have parameter MAX_STEPS, default 32, meaning the count of issued commands at which the block gives up and enters FAULT (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: clock, all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: level-sampled request to begin a rocking session.
REQ-006 SHALL have port abort, input, 1 bit: cancels any session.
REQ-007 SHALL have port cry, input, 1 bit: synchronous cry-detector level, 1 = crying.
REQ-008 SHALL have port A, input, 3 bits: current amplitude from the amplitude/frequency counter block.
REQ-009 SHALL have port F, input, 3 bits: current frequency from the same block.
REQ-010 SHALL have port F0, input, 1 bit: frequency-is-zero flag from the same block.
REQ-011 SHALL have port error, input, 1 bit: command error flag from the same block.
REQ-012 SHALL have ports Alaag, Fhoog and Flaag, outputs, 1 bit each: single-cycle command pulses (amplitude down, frequency up, frequency down).
REQ-013 SHALL have ports busy, done and fault, outputs, 1 bit each: session status flags.
REQ-014 SHALL have port steps, output, 8 bits: number of commands issued in the current session.

Function
REQ-015 SHALL implement states IDLE, SETTLE, DECIDE, ISSUE, DONE and FAULT.
REQ-016 IDLE: start=1 -> SETTLE, with timer loaded to SETTLE_CYCLES-1, steps=0, dir=up, cry_prev=0.
REQ-017 SETTLE: timer decrements each cycle; the transition to DECIDE occurs after exactly SETTLE_CYCLES cycles in SETTLE.
REQ-018 DECIDE lasts one cycle, evaluates in priority order, and ends with one of the outcomes below.
  - error=1 or F0=1 -> FAULT.
  - cry=0 and A==0 -> DONE.
  - cry=0 and A!=0 -> ISSUE with cmd=Alaag; cry_prev cleared to 0.
  - cry=1 -> ISSUE with a frequency command; cry_prev set to 1.
REQ-019 Frequency direction for cry=1, computed in this order:
  - new_dir = dir inverted if cry_prev=1, otherwise dir unchanged.
  - new_dir forced to down if F==7.
  - new_dir forced to up if F<=1.
  - cmd = Fhoog if new_dir=up, Flaag if new_dir=down.
  - dir updated to new_dir.
REQ-020 ISSUE lasts one cycle:
  - exactly the selected command output is 1.
  - steps increments by 1.
  - if the incremented steps equals MAX_STEPS -> FAULT.
  - otherwise -> SETTLE, with timer reloaded to SETTLE_CYCLES-1.
REQ-021 Alaag, Fhoog and Flaag SHALL be registered, SHALL be high only in the ISSUE state, and at most one of them SHALL be high in any cycle.
REQ-022 Latency: start sampled in cycle t gives DECIDE in cycle t+1+SETTLE_CYCLES and the command pulse in cycle t+2+SETTLE_CYCLES.
REQ-023 busy SHALL be 1 in SETTLE, DECIDE and ISSUE, and 0 otherwise.
REQ-024 DONE: done=1 held; start=1 -> SETTLE as in REQ-016; otherwise remain in DONE.
REQ-025 FAULT: fault=1 held; the only exits are abort and reset; start is ignored.
REQ-026 abort=1 in any state -> IDLE next cycle, with no command pulse in that next cycle. abort has priority over start and over all DECIDE/ISSUE outcomes.
REQ-027 steps SHALL saturate and never wrap. steps holds its value in DONE and FAULT, and clears only on a new start, on abort or on reset.
REQ-028 The block SHALL never issue Fhoog when F==7 and never issue Flaag when F<=1.

Reset
REQ-029 reset=1 SHALL immediately force:
  - state IDLE.
  - Alaag, Fhoog, Flaag, busy, done and fault all 0.
  - steps=0, timer=0, dir=up, cry_prev=0.
REQ-030 reset asserted mid-session SHALL suppress any pending pulse, and operation SHALL resume only on a start sampled after reset is released.

Verification
REQ-031 SETTLE_CYCLES=4, A=4, F=4, cry=0; start pulsed in cycle 0 -> busy=1 from cycle 1, Alaag=1 only in cycle 6, next DECIDE in cycle 11.
REQ-032 cry=0 held, A model decrements on each Alaag from 4 -> exactly 4 Alaag pulses, then done=1, busy=0, steps=4.
REQ-033 cry=1 held, F model starting at 4 -> pulse sequence Fhoog, Flaag, Fhoog, ...; with F=7 and cry_prev=0 -> Flaag; with F=1 -> Fhoog.
REQ-034 error=1 or F0=1 during DECIDE -> fault=1 next cycle, no pulse issued; start ignored; abort -> IDLE with fault=0.
REQ-035 MAX_STEPS=3, cry=1 held -> exactly 3 frequency pulses, then fault=1, steps=3.
REQ-036 abort asserted in DECIDE, or reset asserted during SETTLE -> no command pulse follows; outputs match the REQ-029 values; a fresh start then reproduces the REQ-031 timing.

Source files
------------

// File: rtl/rock_strategy.sv
// Rocking-session sequencer: waits for the cradle to settle, samples the cry detector,
// and issues single-cycle amplitude/frequency commands until quiet, or gives up.
module rock_strategy #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_STEPS     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       cry,
  input  logic [2:0] A,
  input  logic [2:0] F,
  input  logic       F0,
  input  logic       error,
  output logic       Alaag,
  output logic       Fhoog,
  output logic       Flaag,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] steps
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DECIDE,
    S_ISSUE,
    S_DONE,
    S_FAULT
  } state_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [8:0] MAX_COUNT   = 9'(MAX_STEPS);
  localparam logic       DIR_UP      = 1'b1;
  localparam logic       DIR_DOWN    = 1'b0;

  state_e     state, state_next;
  logic [7:0] timer, timer_next;
  logic [7:0] steps_next;
  logic [8:0] steps_inc;
  logic       dir, dir_next;
  logic       cry_prev, cry_prev_next;
  logic       new_dir;
  logic       alaag_next, fhoog_next, flaag_next;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    steps_next    = steps;
    dir_next      = dir;
    cry_prev_next = cry_prev;
    alaag_next    = 1'b0;
    fhoog_next    = 1'b0;
    flaag_next    = 1'b0;
    steps_inc     = {1'b0, steps} + 9'd1;

    // Alternate direction on consecutive cries, but never push past either frequency end.
    new_dir = cry_prev ? ~dir : dir;
    if (F == 3'd7) new_dir = DIR_DOWN;
    if (F <= 3'd1) new_dir = DIR_UP;

    if (abort) begin
      state_next    = S_IDLE;
      timer_next    = '0;
      steps_next    = '0;
      dir_next      = DIR_UP;
      cry_prev_next = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_next    = S_SETTLE;
            timer_next    = SETTLE_LOAD;
            steps_next    = '0;
            dir_next      = DIR_UP;
            cry_prev_next = 1'b0;
          end
        end
        S_SETTLE: begin
          if (timer == 8'd0) state_next = S_DECIDE;
          else               timer_next = timer - 8'd1;
        end
        S_DECIDE: begin
          if (error || F0) begin
            state_next = S_FAULT;
          end else if (!cry) begin
            if (A == 3'd0) begin
              state_next = S_DONE;
            end else begin
              state_next    = S_ISSUE;
              alaag_next    = 1'b1;
              cry_prev_next = 1'b0;
            end
          end else begin
            state_next    = S_ISSUE;
            cry_prev_next = 1'b1;
            dir_next      = new_dir;
            fhoog_next    = (new_dir == DIR_UP);
            flaag_next    = (new_dir == DIR_DOWN);
          end
        end
        S_ISSUE: begin
          if (steps != 8'hFF) steps_next = steps_inc[7:0];
          if (steps_inc == MAX_COUNT) begin
            state_next = S_FAULT;
          end else begin
            state_next = S_SETTLE;
            timer_next = SETTLE_LOAD;
          end
        end
        S_FAULT: state_next = S_FAULT;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      steps    <= '0;
      dir      <= DIR_UP;
      cry_prev <= 1'b0;
      Alaag    <= 1'b0;
      Fhoog    <= 1'b0;
      Flaag    <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      steps    <= steps_next;
      dir      <= dir_next;
      cry_prev <= cry_prev_next;
      Alaag    <= alaag_next;
      Fhoog    <= fhoog_next;
      Flaag    <= flaag_next;
    end
  end

  assign busy  = (state == S_SETTLE) || (state == S_DECIDE) || (state == S_ISSUE);
  assign done  = (state == S_DONE);
  assign fault = (state == S_FAULT);

endmodule

// File: tb/tb_rock_strategy.sv
// Self-checking bench for rock_strategy: directed scenarios plus randomized sessions
// checked against a decision-level reference model with a simple A/F plant.
module tb_rock_strategy;

  localparam int S  = 4;
  localparam int M  = 32;
  localparam int MS = 3;

  typedef enum int {O_FAULT, O_DONE, O_ALAAG, O_FHOOG, O_FLAAG} outcome_e;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cry = 1'b0;
  logic [2:0] A = 3'd4;
  logic [2:0] F = 3'd4;
  logic       F0 = 1'b0;
  logic       error = 1'b0;

  logic       Alaag, Fhoog, Flaag, busy, done, fault;
  logic [7:0] steps;
  logic       Alaag_m, Fhoog_m, Flaag_m, busy_m, done_m, fault_m;
  logic [7:0] steps_m;
  logic [2:0] pulses, pulses_m;

  assign pulses   = {Alaag, Fhoog, Flaag};
  assign pulses_m = {Alaag_m, Fhoog_m, Flaag_m};

  int total = 0;
  int bad   = 0;

  int m_steps;
  bit m_dir;
  bit m_cry_prev;

  always #5 clk = ~clk;

  rock_strategy #(.SETTLE_CYCLES(S), .MAX_STEPS(M)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cry(cry),
    .A(A), .F(F), .F0(F0), .error(error),
    .Alaag(Alaag), .Fhoog(Fhoog), .Flaag(Flaag),
    .busy(busy), .done(done), .fault(fault), .steps(steps)
  );

  rock_strategy #(.SETTLE_CYCLES(S), .MAX_STEPS(MS)) dut_m (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cry(cry),
    .A(A), .F(F), .F0(F0), .error(error),
    .Alaag(Alaag_m), .Fhoog(Fhoog_m), .Flaag(Flaag_m),
    .busy(busy_m), .done(done_m), .fault(fault_m), .steps(steps_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pulse_of(input outcome_e o);
    case (o)
      O_ALAAG: return 3'b100;
      O_FHOOG: return 3'b010;
      O_FLAAG: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Decision rules applied to the inputs present during DECIDE.
  task automatic model_decide(output outcome_e o);
    bit nd;
    if (error || F0) begin
      o = O_FAULT;
    end else if (!cry) begin
      if (A == 3'd0) o = O_DONE;
      else begin
        o = O_ALAAG;
        m_cry_prev = 1'b0;
      end
    end else begin
      nd = m_cry_prev ? !m_dir : m_dir;
      if (F == 3'd7) nd = 1'b0;
      if (F <= 3'd1) nd = 1'b1;
      o = nd ? O_FHOOG : O_FLAAG;
      m_dir = nd;
      m_cry_prev = 1'b1;
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    step();
    start = 1'b0;
    m_steps = 0;
    m_dir = 1'b1;
    m_cry_prev = 1'b0;
  endtask

  // Entered on the first SETTLE cycle; leaves on the next SETTLE entry or in DONE/FAULT.
  task automatic do_round(input bit c, output outcome_e o);
    outcome_e e;
    logic [2:0] exp_st;
    cry = c;
    for (int i = 0; i < S; i++) begin
      total++;
      if (pulses !== 3'b000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL settle: pulses=%b busy=%b, want 000/1", pulses, busy);
      end
      step();
    end
    total++;
    if (pulses !== 3'b000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL decide: pulses=%b busy=%b, want 000/1", pulses, busy);
    end
    model_decide(e);
    step();
    total++;
    if (pulses !== pulse_of(e)) begin
      bad++;
      $display("FAIL pulse: got %b want %b (A=%0d F=%0d cry=%b)", pulses, pulse_of(e), A, F, cry);
    end
    if (pulse_of(e) != 3'b000) begin
      m_steps++;
      if (e == O_ALAAG)      A = A - 3'd1;
      else if (e == O_FHOOG) F = F + 3'd1;
      else                   F = F - 3'd1;
      F0 = (F == 3'd0);
      step();
      if (m_steps == M) e = O_FAULT;
    end
    exp_st = {(e != O_DONE && e != O_FAULT), (e == O_DONE), (e == O_FAULT)};
    total++;
    if ({busy, done, fault} !== exp_st || steps !== 8'(m_steps) || pulses !== 3'b000) begin
      bad++;
      $display("FAIL status: busy/done/fault=%b steps=%0d pulses=%b, want %b steps=%0d pulses=000",
               {busy, done, fault}, steps, pulses, exp_st, m_steps);
    end
    o = e;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (pulses !== 3'b000 || {busy, done, fault} !== 3'b000 || steps !== 8'd0) begin
      bad++;
      $display("FAIL abort: pulses=%b busy/done/fault=%b steps=%0d, want 000/000/0",
               pulses, {busy, done, fault}, steps);
    end
  endtask

  // Start in cycle 0 with A=4, cry=0 held: busy from cycle 1, Alaag in cycles 6 and 12.
  task automatic check_timing();
    logic exp_a;
    A = 3'd4; F = 3'd4; F0 = 1'b0; error = 1'b0; cry = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
      exp_a = (c == 6 || c == 12);
      total++;
      if (busy !== 1'b1 || Alaag !== exp_a || Fhoog !== 1'b0 || Flaag !== 1'b0) begin
        bad++;
        $display("FAIL timing c=%0d: busy=%b pulses=%b, want busy=1 Alaag=%b", c, busy, pulses, exp_a);
      end
    end
    do_abort();
  endtask

  task automatic test_reset();
    step();
    total++;
    if (pulses !== 3'b000 || {busy, done, fault} !== 3'b000 || steps !== 8'd0) begin
      bad++;
      $display("FAIL reset: pulses=%b flags=%b steps=%0d, want all 0", pulses, {busy, done, fault}, steps);
    end
    reset = 1'b0;
    step();
    step();
    total++;
    if (pulses !== 3'b000 || {busy, done, fault} !== 3'b000 || steps !== 8'd0) begin
      bad++;
      $display("FAIL idle_after_reset: pulses=%b flags=%b steps=%0d, want all 0",
               pulses, {busy, done, fault}, steps);
    end
  endtask

  task automatic test_amp_down();
    outcome_e o, want;
    A = 3'd4; F = 3'd4; F0 = 1'b0; error = 1'b0;
    start_session();
    for (int r = 0; r < 5; r++) begin
      do_round(1'b0, o);
      want = (r < 4) ? O_ALAAG : O_DONE;
      total++;
      if (o != want) begin
        bad++;
        $display("FAIL amp_seq r=%0d: got %s want %s", r, o.name(), want.name());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || steps !== 8'd4 || pulses !== 3'b000) begin
        bad++;
        $display("FAIL done_hold: done=%b busy=%b steps=%0d pulses=%b, want 1/0/4/000",
                 done, busy, steps, pulses);
      end
    end
  endtask

  task automatic test_freq();
    outcome_e o;
    outcome_e seq[4] = '{O_FHOOG, O_FLAAG, O_FHOOG, O_FLAAG};
    F = 3'd4; F0 = 1'b0; error = 1'b0;
    start_session();
    for (int r = 0; r < 4; r++) begin
      do_round(1'b1, o);
      total++;
      if (o != seq[r]) begin
        bad++;
        $display("FAIL freq_seq r=%0d: got %s want %s", r, o.name(), seq[r].name());
      end
    end
    do_abort();
    F = 3'd7;
    start_session();
    do_round(1'b1, o);
    total++;
    if (o != O_FLAAG) begin
      bad++;
      $display("FAIL freq_top: got %s want O_FLAAG", o.name());
    end
    do_abort();
    F = 3'd1;
    start_session();
    do_round(1'b1, o);
    total++;
    if (o != O_FHOOG) begin
      bad++;
      $display("FAIL freq_bottom: got %s want O_FHOOG", o.name());
    end
    do_abort();
  endtask

  task automatic test_fault();
    outcome_e o;
    A = 3'd4; F = 3'd4; F0 = 1'b0;
    start_session();
    error = 1'b1;
    do_round(1'b0, o);
    error = 1'b0;
    total++;
    if (o != O_FAULT) begin
      bad++;
      $display("FAIL fault_error: got %s want O_FAULT", o.name());
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (fault !== 1'b1 || busy !== 1'b0 || pulses !== 3'b000) begin
        bad++;
        $display("FAIL fault_hold: fault=%b busy=%b pulses=%b, want 1/0/000", fault, busy, pulses);
      end
    end
    start = 1'b0;
    do_abort();
    F0 = 1'b1;
    start_session();
    do_round(1'b1, o);
    F0 = 1'b0;
    total++;
    if (o != O_FAULT) begin
      bad++;
      $display("FAIL fault_f0: got %s want O_FAULT", o.name());
    end
    do_abort();
  endtask

  task automatic test_max_steps();
    logic [2:0] seq[3] = '{3'b010, 3'b001, 3'b010};
    reset = 1'b1;
    step();
    reset = 1'b0;
    A = 3'd4; F = 3'd4; F0 = 1'b0; error = 1'b0; cry = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i <= S; i++) begin
        total++;
        if (pulses_m !== 3'b000) begin
          bad++;
          $display("FAIL max_gap r=%0d: pulses=%b want 000", r, pulses_m);
        end
        step();
      end
      total++;
      if (pulses_m !== seq[r]) begin
        bad++;
        $display("FAIL max_pulse r=%0d: got %b want %b", r, pulses_m, seq[r]);
      end
      step();
      total++;
      if (r < 2 && ({busy_m, fault_m} !== 2'b10 || steps_m !== 8'(r + 1))) begin
        bad++;
        $display("FAIL max_mid r=%0d: busy/fault=%b steps=%0d", r, {busy_m, fault_m}, steps_m);
      end else if (r == 2 && ({busy_m, fault_m} !== 2'b01 || steps_m !== 8'd3)) begin
        bad++;
        $display("FAIL max_end: busy/fault=%b steps=%0d, want 01/3", {busy_m, fault_m}, steps_m);
      end
    end
    start = 1'b1;
    for (int i = 0; i < 3 * (S + 2); i++) begin
      step();
      total++;
      if (pulses_m !== 3'b000 || fault_m !== 1'b1 || steps_m !== 8'd3) begin
        bad++;
        $display("FAIL max_hold: pulses=%b fault=%b steps=%0d", pulses_m, fault_m, steps_m);
      end
    end
    start = 1'b0;
    cry = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_abort_reset();
    A = 3'd4; F = 3'd4; F0 = 1'b0; error = 1'b0; cry = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < S; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pulses !== 3'b000 || {busy, done, fault} !== 3'b000 || steps !== 8'd0) begin
        bad++;
        $display("FAIL abort_decide i=%0d: pulses=%b flags=%b steps=%0d", i, pulses, {busy, done, fault}, steps);
      end
      step();
    end
    check_timing();

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    total++;
    if (pulses !== 3'b000 || {busy, done, fault} !== 3'b000 || steps !== 8'd0) begin
      bad++;
      $display("FAIL reset_async: pulses=%b flags=%b steps=%0d", pulses, {busy, done, fault}, steps);
    end
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < S + 3; i++) begin
      step();
      total++;
      if (pulses !== 3'b000 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_release i=%0d: pulses=%b busy=%b, want 000/0", i, pulses, busy);
      end
    end
    check_timing();
  endtask

  task automatic test_random();
    outcome_e o;
    bit c;
    o = O_DONE;
    for (int s = 0; s < 15; s++) begin
      A  = 3'($urandom_range(0, 7));
      F  = 3'($urandom_range(1, 7));
      F0 = 1'b0;
      start_session();
      for (int r = 0; r < 40; r++) begin
        error = ($urandom_range(0, 15) == 0);
        c = 1'($urandom_range(0, 1));
        do_round(c, o);
        error = 1'b0;
        if (o == O_DONE || o == O_FAULT) break;
      end
      if (o != O_DONE) do_abort();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    check_timing();
    test_amp_down();
    test_freq();
    test_fault();
    test_max_steps();
    test_abort_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
